// File: rtl/jam_cost_table.sv
// Cost-matrix store for the JAM search engine: streaming row-major load, then 1-cycle lookups.
// Optional JAM_COST_LB_EN adds lb_cost, the sum of per-column minima, for engine pruning.
module jam_cost_table #(
  parameter int unsigned N      = 8,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned COST_W = 7
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ld_valid,
  input  logic [COST_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              reload,
  output logic              table_ready,
  output logic              load_err,
  input  logic [IDX_W-1:0]  W,
  input  logic [IDX_W-1:0]  J,
  output logic [COST_W-1:0] Cost,
  output logic [15:0]       rd_cnt
`ifdef JAM_COST_LB_EN
  ,
  output logic [$clog2(N*(2**COST_W-1)+1)-1:0] lb_cost
`endif
);

  localparam int unsigned Entries = N * N;
  localparam int unsigned PtrW    = $clog2(Entries);
  localparam int unsigned IdxW2   = 2 * IDX_W;

  typedef enum logic {StLoad, StServe} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic                table_ready_q, table_ready_d;
  logic                load_err_q, load_err_d;
  logic [COST_W-1:0]   cost_q, cost_d;
  logic [15:0]         rd_cnt_q, rd_cnt_d;
  logic [COST_W-1:0]   mem [Entries];

  logic                accept;
  logic                last_beat;
  logic                in_range;
  logic [IdxW2-1:0]    rd_idx;

  assign accept    = ld_valid && ld_ready;
  assign last_beat = (wr_ptr_q == PtrW'(Entries - 1));
  assign rd_idx    = IdxW2'(W) * IdxW2'(N) + IdxW2'(J);
  assign in_range  = (32'(W) < N) && (32'(J) < N);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= StLoad;
      wr_ptr_q      <= '0;
      table_ready_q <= 1'b0;
      load_err_q    <= 1'b0;
      cost_q        <= '0;
      rd_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      table_ready_q <= table_ready_d;
      load_err_q    <= load_err_d;
      cost_q        <= cost_d;
      rd_cnt_q      <= rd_cnt_d;
    end
  end

  // Storage has no reset; a complete load always precedes any lookup.
  always_ff @(posedge CLK) begin
    if (accept) mem[wr_ptr_q] <= ld_data;
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    table_ready_d = table_ready_q;
    load_err_d    = load_err_q;
    cost_d        = cost_q;
    rd_cnt_d      = rd_cnt_q;
    if (reload) begin
      state_d       = StLoad;
      wr_ptr_d      = '0;
      table_ready_d = 1'b0;
      load_err_d    = 1'b0;
      cost_d        = '0;
    end else begin
      unique case (state_q)
        StLoad: begin
          cost_d = '0;
          if (accept) begin
            if (last_beat) begin
              state_d       = StServe;
              wr_ptr_d      = '0;
              table_ready_d = 1'b1;
              rd_cnt_d      = '0;
              if (!ld_last) load_err_d = 1'b1;
            end else if (ld_last) begin
              // Early last: restart the stream from entry 0.
              load_err_d = 1'b1;
              wr_ptr_d   = '0;
            end else begin
              wr_ptr_d = wr_ptr_q + 1'b1;
            end
          end
        end
        StServe: begin
          cost_d = in_range ? mem[rd_idx] : '0;
          if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
        end
      endcase
    end
  end

  always_comb begin
    ld_ready = (state_q == StLoad) && !reload;
  end

  assign table_ready = table_ready_q;
  assign load_err    = load_err_q;
  assign Cost        = cost_q;
  assign rd_cnt      = rd_cnt_q;

`ifdef JAM_COST_LB_EN
  localparam int unsigned LbW = $clog2(N*(2**COST_W-1)+1);

  logic [COST_W-1:0] colmin_q [N];
  logic [COST_W-1:0] colmin_d [N];
  logic [COST_W-1:0] colmin_upd [N];
  logic [LbW-1:0]    lb_q, lb_d, lb_sum;
  logic [IDX_W-1:0]  col_sel;
  logic              row0;

  always_comb begin
    col_sel = IDX_W'(32'(wr_ptr_q) % N);
    row0    = (32'(wr_ptr_q) < N);
    lb_sum  = '0;
    for (int j = 0; j < int'(N); j++) begin
      colmin_upd[j] = colmin_q[j];
      if (accept && (col_sel == IDX_W'(j)) && (row0 || (ld_data < colmin_q[j]))) begin
        colmin_upd[j] = ld_data;
      end
      lb_sum = lb_sum + LbW'(colmin_upd[j]);
    end
    colmin_d = colmin_q;
    lb_d     = lb_q;
    if (reload) begin
      colmin_d = '{default: '0};
      lb_d     = '0;
    end else if (accept) begin
      if (last_beat) begin
        colmin_d = colmin_upd;
        lb_d     = lb_sum;
      end else if (ld_last) begin
        colmin_d = '{default: '0};
      end else begin
        colmin_d = colmin_upd;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      colmin_q <= '{default: '0};
      lb_q     <= '0;
    end else begin
      colmin_q <= colmin_d;
      lb_q     <= lb_d;
    end
  end

  assign lb_cost = lb_q;
`endif

endmodule

// File: tb/tb_jam_cost_table.sv
// Randomised bench for jam_cost_table: queue-based load model, per-cycle compare, literal pins.
module tb_jam_cost_table;
  localparam int N = 8;
  localparam int E = N * N;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       ld_valid = 1'b0;
  logic [6:0] ld_data = '0;
  logic       ld_last = 1'b0;
  logic       ld_ready;
  logic       reload = 1'b0;
  logic       table_ready;
  logic       load_err;
  logic [2:0] W = '0;
  logic [2:0] J = '0;
  logic [6:0] Cost;
  logic [15:0] rd_cnt;
`ifdef JAM_COST_LB_EN
  logic [9:0] lb_cost;
`endif

  jam_cost_table dut (
    .CLK(CLK), .RST(RST), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .reload(reload), .table_ready(table_ready), .load_err(load_err),
    .W(W), .J(J), .Cost(Cost), .rd_cnt(rd_cnt)
`ifdef JAM_COST_LB_EN
    , .lb_cost(lb_cost)
`endif
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: accepted beats collect in a queue; 64 of them become the table.
  bit m_load = 1'b1;
  bit m_ready = 1'b0;
  bit m_err = 1'b0;
  int m_cost = 0;
  int m_rd = 0;
  int m_lb = 0;
  int q[$];
  int tbl[E];

  function automatic int col_min_sum();
    int s = 0;
    for (int c = 0; c < N; c++) begin
      int m = tbl[c];
      for (int r = 1; r < N; r++) if (tbl[r*N+c] < m) m = tbl[r*N+c];
      s += m;
    end
    return s;
  endfunction

  initial begin
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
        m_load = 1; m_ready = 0; m_err = 0; m_cost = 0; m_rd = 0; m_lb = 0;
        q.delete();
      end else if (reload) begin
        m_load = 1; m_ready = 0; m_err = 0; m_cost = 0; m_lb = 0;
        q.delete();
      end else if (m_load) begin
        m_cost = 0;
        if (ld_valid) begin
          q.push_back(int'(ld_data));
          if (q.size() == E) begin
            for (int k = 0; k < E; k++) tbl[k] = q[k];
            q.delete();
            m_load = 0; m_ready = 1; m_rd = 0;
            if (!ld_last) m_err = 1;
            m_lb = col_min_sum();
          end else if (ld_last) begin
            m_err = 1;
            q.delete();
          end
        end
      end else begin
        m_cost = (int'(W) < N && int'(J) < N) ? tbl[int'(W)*N + int'(J)] : 0;
        m_rd = (m_rd < 65535) ? m_rd + 1 : 65535;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (!RST) begin
        chk("ld_ready", int'(ld_ready), int'(m_load && !reload));
        chk("table_ready", int'(table_ready), int'(m_ready));
        chk("load_err", int'(load_err), int'(m_err));
        chk("Cost", int'(Cost), m_cost);
        chk("rd_cnt", int'(rd_cnt), m_rd);
`ifdef JAM_COST_LB_EN
        chk("lb_cost", int'(lb_cost), m_lb);
`endif
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_idx();
    W = 3'($urandom_range(0, 7));
    J = 3'($urandom_range(0, 7));
  endtask

  // kind 0: (W*8+J)%100, kind 1: 100 off-diagonal / 5+J on diagonal, kind 2: random.
  task automatic send(input int last_at, input int nbeats, input int gap_pct, input int kind);
    for (int i = 0; i < nbeats; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        ld_valid = 1'b0;
        ld_last  = 1'($urandom_range(0, 1));
        ld_data  = 7'($urandom_range(0, 127));
        rand_idx();
        step();
      end
      ld_valid = 1'b1;
      ld_last  = (i == last_at);
      case (kind)
        0:       ld_data = 7'(i % 100);
        1:       ld_data = (i / N == i % N) ? 7'(5 + i % N) : 7'd100;
        default: ld_data = 7'($urandom_range(0, 127));
      endcase
      rand_idx();
      step();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic serve(input int n);
    for (int i = 0; i < n; i++) begin
      rand_idx();
      ld_valid = 1'($urandom_range(0, 1));
      ld_data  = 7'($urandom_range(0, 127));
      step();
    end
    ld_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  initial begin
    #3;
    chk("reset table_ready", int'(table_ready), 0);
    chk("reset load_err", int'(load_err), 0);
    chk("reset Cost", int'(Cost), 0);
    chk("reset rd_cnt", int'(rd_cnt), 0);
    chk("reset ld_ready", int'(ld_ready), 1);
    step();
    step();
    RST = 1'b0;

    // 1: straight 64-beat load, then fixed lookups
    send(63, 64, 0, 0);
    chk("t1 table_ready", int'(table_ready), 1);
    chk("t1 load_err", int'(load_err), 0);
    chk("t1 rd_cnt", int'(rd_cnt), 0);
    W = 3'd3; J = 3'd5;
    step();
    chk("t1 cost(3,5)", int'(Cost), 29);
    W = 3'd7; J = 3'd7;
    step();
    chk("t1 cost(7,7)", int'(Cost), 63);
    serve(20);

    // 2: gappy load with the same data
    pulse_reload();
    send(63, 64, 50, 0);
    chk("t2 table_ready", int'(table_ready), 1);
    serve(12);

    // 3: early last on beat 10, then a full random stream
    pulse_reload();
    send(10, 11, 0, 0);
    chk("t3 load_err early", int'(load_err), 1);
    chk("t3 table_ready early", int'(table_ready), 0);
    send(63, 64, 30, 2);
    chk("t3 table_ready", int'(table_ready), 1);
    chk("t3 load_err sticky", int'(load_err), 1);
    serve(12);

    // 4: reload coincident with a beat in SERVE
    reload = 1'b1; ld_valid = 1'b1; ld_data = 7'd5; ld_last = 1'b1;
    step();
    reload = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    chk("t4 table_ready", int'(table_ready), 0);
    chk("t4 Cost", int'(Cost), 0);
    serve(0);
    send(63, 64, 0, 0);
    chk("t4 rd_cnt cleared", int'(rd_cnt), 0);
    serve(6);

    // 5: asynchronous reset mid-load
    pulse_reload();
    send(-1, 30, 0, 2);
    RST = 1'b1;
    #1;
    chk("t5 rd_cnt async", int'(rd_cnt), 0);
    chk("t5 table_ready async", int'(table_ready), 0);
    chk("t5 Cost async", int'(Cost), 0);
    step();
    RST = 1'b0;
    send(63, 64, 20, 2);
    serve(10);

    // 6: diagonal lower-bound matrix
    pulse_reload();
    send(63, 64, 0, 1);
`ifdef JAM_COST_LB_EN
    chk("t6 lb_cost", int'(lb_cost), 68);
`endif
    serve(8);

    for (int it = 0; it < 8; it++) begin
      pulse_reload();
      if ($urandom_range(0, 1) == 1) begin
        int at = $urandom_range(0, 62);
        send(at, at + 1, 40, 2);
      end
      send($urandom_range(0, 1) == 1 ? 63 : -1, 64, $urandom_range(0, 60), 2);
      serve($urandom_range(3, 25));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/jam_cost_table.md
Name: jam_cost_table

Overview:
Upstream cost source for the job-assignment (JAM) search engine.
- Receives an N×N worker/job cost matrix over a streaming load interface and stores it in registers.
- Once loaded, answers the engine's (W, J) lookups with the same fixed one-cycle registered latency the engine expects on its Cost input.
- Holds the engine-facing side quiet until the table is complete. The engine's reset is gated from table_ready at top level.

Parameters:
N, 8, number of workers and jobs; the matrix has N*N entries.
IDX_W, 3, width of W/J indices; must satisfy 2**IDX_W >= N.
COST_W, 7, width of one cost entry.

Ports:
CLK  input  1  clock
RST  input  1  reset; asynchronous, active-high
ld_valid  input  1  load beat valid
ld_data  input  COST_W  cost entry; row-major order, entry index = W*N+J
ld_last  input  1  marks the final beat of the matrix
ld_ready  output  1  load beat accepted when ld_valid && ld_ready
reload  input  1  single-cycle pulse; discard the table and start a new load
table_ready  output  1  table complete, lookups valid
load_err  output  1  sticky; framing error seen during the current load
W  input  IDX_W  worker index from the engine
J  input  IDX_W  job index from the engine
Cost  output  COST_W  registered cost of (W, J)
rd_cnt  output  16  lookups served since the last table completion; saturating

Behaviour:
- Reset values: state=LOAD, wr_ptr=0, table_ready=0, load_err=0, Cost=0, rd_cnt=0. Storage contents are don't-care.
- Two states: LOAD and SERVE.
- ld_ready = (state==LOAD) && !reload. This is combinational; it is never asserted in SERVE.
- LOAD:
  - On an accepted beat, write mem[wr_ptr] <= ld_data and increment wr_ptr.
  - ld_last on a beat with wr_ptr < N*N-1 (early last): set load_err=1, wr_ptr <= 0, stay in LOAD. Beats already written are overwritten by the restarted stream.
  - Beat with wr_ptr == N*N-1: always accepted. If ld_last==0 on that beat, set load_err=1 anyway. Then next state is SERVE and wr_ptr <= 0.
  - table_ready rises the cycle after the final beat is accepted.
  - Cost is held at 0 throughout LOAD.
- SERVE:
  - Every cycle, Cost <= mem[W*N+J]. Latency is exactly 1 cycle: W/J sampled at edge k appear on Cost after edge k.
  - If W>=N or J>=N, Cost <= 0.
  - rd_cnt increments every SERVE cycle and saturates at 16'hFFFF.
  - ld_valid is ignored and nothing is written.
- reload:
  - In any state, next state is LOAD, with wr_ptr <= 0, table_ready <= 0, load_err <= 0, Cost <= 0.
  - rd_cnt holds its value during LOAD and clears to 0 on entry to SERVE.
  - reload in the same cycle as ld_valid: reload wins and the beat is not accepted, because ld_ready=0.
- Index arithmetic: W*N+J is computed at width 2*IDX_W. No wrap is possible for in-range indices.
- Asserting RST mid-load or mid-serve returns immediately to the reset values, and a full new load is required.

Optional Feature:
JAM_COST_LB_EN
- With the macro defined, add output lb_cost [9:0] (width ceil(log2(N*(2**COST_W-1)+1)); 10 for the defaults).
- During LOAD, per-column minima colmin[j] are tracked. colmin[j] is initialised on row 0 and updated with min on later rows.
- On table completion, lb_cost = sum of colmin[0..N-1], valid in the same cycle table_ready rises. The lower bound lets the engine prune.
- lb_cost is 0 in LOAD, and reload and early-last clear the minima.
- Without the macro: no port, no minima registers.

Test Plan:
1. Reset, then stream 64 beats with ld_data=(W*8+J)%100, ld_valid held high, ld_last on beat 63.
   - ld_ready=1 for 64 cycles. table_ready=1 on the next cycle. load_err=0.
   - Then drive W=3, J=5: Cost=29 one cycle later. W=7, J=7: Cost=63.
2. Random ld_valid gaps (about 50% duty) with the same data.
   - Identical final table. table_ready rises only after the 64th accepted beat.
3. ld_last asserted on beat 10, then a correct 64-beat stream.
   - load_err=1 from beat 11 onward. wr_ptr restarts. Table matches the second stream. table_ready=1 with load_err still 1.
4. In SERVE, reload pulse coincident with ld_valid=1.
   - That beat is not written. table_ready=0 and Cost=0 next cycle. rd_cnt holds; a new 64-beat load is required, then rd_cnt=0 in SERVE.
5. RST asserted after 30 beats.
   - Outputs return to reset values asynchronously. Loading restarts from entry 0.
6. (JAM_COST_LB_EN) Matrix with all 100 except the diagonal at 5+J.
   - lb_cost=68 when table_ready rises.
